// File: rtl/nvdla_csb_sequencer.sv
// One CSB register access per start pulse: request handshake, response,
// optional interrupt wait, watchdog timeout, done pulse.
module nvdla_csb_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic              write_i,
  input  logic              wait_intr_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic              csb_req_valid_o,
  input  logic              csb_req_ready_i,
  output logic [ADDR_W-1:0] csb_addr_o,
  output logic [DATA_W-1:0] csb_wdat_o,
  output logic              csb_write_o,
  output logic              csb_nposted_o,
  input  logic              csb_rdata_valid_i,
  input  logic [DATA_W-1:0] csb_rdata_i,
  input  logic              csb_wr_complete_i,
  input  logic              intr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RESP, S_INTR, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdat_q;
  logic                 write_q;
  logic                 wait_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 seen_q;
  logic                 error_q;

  logic latch;
  logic cap;
  logic set_err;
  logic resp;
  logic tmo;

  // Saturating count; >= so a limit passed during a response still fires later
  assign cnt_inc = (cnt_q == {TIMEOUT_W{1'b1}}) ? cnt_q
                 : cnt_q + TIMEOUT_W'(1);
  assign tmo  = (timeout_i != '0) && (cnt_inc >= timeout_i);
  assign resp = write_q ? csb_wr_complete_i : csb_rdata_valid_i;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cap     = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          latch   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (csb_req_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp) begin
          cap     = !write_q;
          state_d = wait_q ? S_INTR : S_DONE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_INTR: begin
        if (intr_i || seen_q) begin
          state_d = S_DONE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      write_q <= 1'b0;
      wait_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= addr_i;
        wdat_q  <= wdat_i;
        write_q <= write_i;
        wait_q  <= wait_intr_i;
        cnt_q   <= '0;
        seen_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if (state_q == S_REQ && csb_req_ready_i) cnt_q <= '0;
      if (state_q == S_RESP || state_q == S_INTR) cnt_q <= cnt_inc;
      if ((state_q == S_REQ || state_q == S_RESP) && intr_i) seen_q <= 1'b1;
      if (cap) rdata_q <= csb_rdata_i;
      if (set_err) error_q <= 1'b1;
    end
  end

  assign csb_req_valid_o = (state_q == S_REQ);
  assign csb_addr_o      = addr_q;
  assign csb_wdat_o      = wdat_q;
  assign csb_write_o     = write_q;
  assign csb_nposted_o   = write_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign rdata_o         = rdata_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_nvdla_csb_sequencer.sv
// Bench for nvdla_csb_sequencer: directed vector table, hand sequences for
// clear/reset, and random transactions against a timeline model.
module tb_nvdla_csb_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, start_i;
  logic [15:0] addr_i;
  logic [31:0] wdat_i;
  logic        write_i, wait_intr_i;
  logic [15:0] timeout_i;
  logic        csb_req_valid_o, csb_req_ready_i;
  logic [15:0] csb_addr_o;
  logic [31:0] csb_wdat_o;
  logic        csb_write_o, csb_nposted_o;
  logic        csb_rdata_valid_i;
  logic [31:0] csb_rdata_i;
  logic        csb_wr_complete_i, intr_i;
  logic        busy_o, done_o, error_o;
  logic [31:0] rdata_o;

  always #5 clk_i = ~clk_i;

  nvdla_csb_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .start_i(start_i), .addr_i(addr_i), .wdat_i(wdat_i),
    .write_i(write_i), .wait_intr_i(wait_intr_i),
    .timeout_i(timeout_i),
    .csb_req_valid_o(csb_req_valid_o),
    .csb_req_ready_i(csb_req_ready_i),
    .csb_addr_o(csb_addr_o), .csb_wdat_o(csb_wdat_o),
    .csb_write_o(csb_write_o), .csb_nposted_o(csb_nposted_o),
    .csb_rdata_valid_i(csb_rdata_valid_i),
    .csb_rdata_i(csb_rdata_i),
    .csb_wr_complete_i(csb_wr_complete_i), .intr_i(intr_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .error_o(error_o)
  );

  // r: response edge offset after handshake (0 = never)
  // intr_at: edge index of a 1-cycle intr pulse (0 = none)
  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        wait_intr;
    int          dr;
    int          r;
    int          intr_at;
    logic [15:0] tmo;
    int          exp_d;
    bit          exp_err;
  } txn_t;

  localparam int NEVER = 1 << 30;

  int checks = 0;
  int failures = 0;
  int curk;
  logic [31:0] exp_rdata;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", nm, curk, got, exp);
    end
  endtask

  task automatic quiet();
    start_i = 0; clear_i = 0; intr_i = 0;
    csb_req_ready_i = 0; csb_rdata_valid_i = 0;
    csb_wr_complete_i = 0; csb_rdata_i = 0;
  endtask

  // Edge 0 samples start; edge h=1+dr is the handshake; response at h+r.
  function automatic void model(input txn_t t, output int d,
                                output bit err);
    int h, rr, te, ie;
    h  = 1 + t.dr;
    rr = (t.r > 0) ? h + t.r : NEVER;
    te = (t.tmo != 0) ? h + int'(t.tmo) : NEVER;
    err = 0;
    if (rr > te) begin
      d = te; err = 1;
    end else if (!t.wait_intr) begin
      d = rr;
    end else if (t.intr_at > 0 && t.intr_at <= rr) begin
      d = rr + 1;
    end else begin
      ie = (t.intr_at > rr) ? t.intr_at : NEVER;
      if (te != NEVER && te < rr + 1) te = rr + 1;
      if (ie <= te) d = ie;
      else begin d = te; err = 1; end
    end
  endfunction

  task automatic run_txn(input txn_t t, input int d, input bit err,
                         input string nm);
    int h, rr;
    h  = 1 + t.dr;
    rr = (t.r > 0) ? h + t.r : -1;
    if (d > 5000) begin
      curk = -1;
      chk({nm, "_bound"}, 64'(d), 64'(5000));
      return;
    end
    for (int k = 0; k <= d + 2; k++) begin
      @(negedge clk_i);
      curk = k;
      start_i = (k == 0) ? 1'b1 : (k <= d + 1) ? 1'($urandom) : 1'b0;
      if (k == 0) begin
        addr_i = t.addr; wdat_i = t.wdat;
        write_i = t.write; wait_intr_i = t.wait_intr;
      end else begin
        addr_i = 16'($urandom); wdat_i = $urandom;
        write_i = 1'($urandom); wait_intr_i = 1'($urandom);
      end
      timeout_i = t.tmo;
      csb_req_ready_i = (k < h) ? 1'b0 : (k == h) ? 1'b1 : 1'($urandom);
      csb_rdata_i = (k == rr) ? t.rdat : $urandom;
      csb_rdata_valid_i = t.write ? 1'($urandom)
                        : ((k == rr) || (k > d && 1'($urandom)));
      csb_wr_complete_i = !t.write ? 1'($urandom)
                        : ((k == rr) || (k > d && 1'($urandom)));
      intr_i = (k == t.intr_at);
      @(posedge clk_i); #1;
      if (!t.write && rr > 0 && k == rr && rr <= d) exp_rdata = t.rdat;
      chk({nm, "_done"}, 64'(done_o), 64'(k == d));
      chk({nm, "_busy"}, 64'(busy_o), 64'(k <= d));
      chk({nm, "_valid"}, 64'(csb_req_valid_o), 64'(k < h));
      chk({nm, "_error"}, 64'(error_o), 64'((k >= d) ? err : 1'b0));
      chk({nm, "_rdata"}, 64'(rdata_o), 64'(exp_rdata));
      if (k < h) begin
        chk({nm, "_addr"}, 64'(csb_addr_o), 64'(t.addr));
        chk({nm, "_wdat"}, 64'(csb_wdat_o), 64'(t.wdat));
        chk({nm, "_write"}, 64'(csb_write_o), 64'(t.write));
        chk({nm, "_npost"}, 64'(csb_nposted_o), 64'(t.write));
      end
    end
    quiet();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(csb_req_valid_o), 64'(0));
    chk({nm, "_busy"}, 64'(busy_o), 64'(0));
    chk({nm, "_done"}, 64'(done_o), 64'(0));
    chk({nm, "_error"}, 64'(error_o), 64'(0));
    chk({nm, "_rdata"}, 64'(rdata_o), 64'(0));
    chk({nm, "_addr"}, 64'(csb_addr_o), 64'(0));
    chk({nm, "_wdat"}, 64'(csb_wdat_o), 64'(0));
    chk({nm, "_write"}, 64'(csb_write_o), 64'(0));
    chk({nm, "_npost"}, 64'(csb_nposted_o), 64'(0));
  endtask

  task automatic edge_step();
    @(posedge clk_i); #1;
  endtask

  txn_t vec[11];

  initial begin
    txn_t t;
    int d;
    bit err;
    vec[0]  = '{1, 16'h5010, 32'h0000_1234, 0, 0, 0, 3, 0, 0, 4, 0};
    vec[1]  = '{0, 16'h0004, 0, 32'hCAFE_F00D, 0, 5, 1, 0, 0, 7, 0};
    vec[2]  = '{1, 16'h0100, 32'hA5A5_0001, 0, 1, 0, 3, 2, 0, 5, 0};
    vec[3]  = '{0, 16'h0008, 0, 32'h1111_2222, 0, 0, 0, 0, 8, 9, 1};
    vec[4]  = '{0, 16'h000C, 0, 32'h3333_4444, 0, 0, 1000, 0, 0, 1001, 0};
    vec[5]  = '{0, 16'h0010, 0, 32'h5555_6666, 0, 0, 1, 0, 0, 2, 0};
    vec[6]  = '{0, 16'h0014, 0, 32'h7777_8888, 1, 0, 2, 6, 0, 6, 0};
    vec[7]  = '{1, 16'h0018, 32'hDEAD_BEEF, 0, 1, 0, 1, 0, 5, 6, 1};
    vec[8]  = '{0, 16'h001C, 0, 32'h9999_AAAA, 0, 0, 4, 0, 4, 5, 0};
    vec[9]  = '{0, 16'h0020, 0, 32'hBBBB_CCCC, 1, 0, 4, 7, 4, 6, 1};
    vec[10] = '{0, 16'h0024, 0, 32'hDDDD_EEEE, 1, 2, 2, 1, 0, 6, 0};

    curk = 0;
    exp_rdata = 0;
    quiet();
    rst_ni = 0; addr_i = 16'h1234; wdat_i = 32'h5678;
    write_i = 1; wait_intr_i = 0; timeout_i = 0;
    edge_step();
    edge_step();
    chk_zero("reset");
    @(negedge clk_i);
    rst_ni = 1;

    for (int i = 0; i < 11; i++)
      run_txn(vec[i], vec[i].exp_d, vec[i].exp_err, $sformatf("vec%0d", i));

    // clear during WAIT_RESP, then a late response
    @(negedge clk_i);
    start_i = 1; write_i = 0; addr_i = 16'h0040; csb_req_ready_i = 1;
    edge_step();
    @(negedge clk_i); start_i = 0;
    edge_step();
    chk("clr_inresp", 64'(busy_o), 64'(1));
    @(negedge clk_i); clear_i = 1;
    edge_step();
    exp_rdata = 0;
    chk("clr_busy", 64'(busy_o), 64'(0));
    chk("clr_valid", 64'(csb_req_valid_o), 64'(0));
    chk("clr_done", 64'(done_o), 64'(0));
    @(negedge clk_i);
    clear_i = 0; csb_rdata_valid_i = 1; csb_rdata_i = 32'h55AA_55AA;
    edge_step();
    @(negedge clk_i); csb_rdata_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      curk = k;
      edge_step();
      chk("clr_late_rdata", 64'(rdata_o), 64'(0));
      chk("clr_late_done", 64'(done_o), 64'(0));
      chk("clr_late_busy", 64'(busy_o), 64'(0));
    end

    // clear and start together: clear wins
    @(negedge clk_i); clear_i = 1; start_i = 1;
    edge_step();
    chk("clrstart_busy", 64'(busy_o), 64'(0));
    @(negedge clk_i); clear_i = 0; start_i = 0;

    // reset mid-REQUEST, with start also high
    @(negedge clk_i);
    start_i = 1; write_i = 1; addr_i = 16'hBEEF; wdat_i = 32'hFACE;
    csb_req_ready_i = 0;
    edge_step();
    chk("rst_req_valid", 64'(csb_req_valid_o), 64'(1));
    chk("rst_req_addr", 64'(csb_addr_o), 64'(16'hBEEF));
    @(negedge clk_i); rst_ni = 0;
    edge_step();
    chk_zero("rst_mid");
    @(negedge clk_i); rst_ni = 1; start_i = 0;

    for (int n = 0; n < 150; n++) begin
      t.write = 1'($urandom);
      t.addr = 16'($urandom);
      t.wdat = $urandom;
      t.rdat = $urandom;
      t.wait_intr = 1'($urandom);
      t.dr = $urandom_range(0, 4);
      t.r = $urandom_range(0, 12);
      t.intr_at = $urandom_range(0, 20);
      t.tmo = ($urandom_range(0, 2) == 0) ? 16'd0
            : 16'($urandom_range(1, 12));
      if (t.tmo == 0 && t.r == 0) t.r = $urandom_range(1, 12);
      if (t.tmo == 0 && t.wait_intr && t.intr_at == 0) t.intr_at = 3;
      if (t.tmo == 0 && t.wait_intr && t.intr_at > 0 &&
          t.intr_at > 1 + t.dr + t.r) t.intr_at = t.intr_at;
      if (t.tmo == 0 && t.wait_intr) t.intr_at = t.intr_at + 0;
      model(t, d, err);
      t.exp_d = d;
      t.exp_err = err;
      run_txn(t, d, err, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog k=%0d got=timeout exp=finish", curk);
    $fatal(1, "bench watchdog expired");
  end

endmodule
